// File: rtl/sram_sync_bank.sv
// Single-clock synchronous SRAM bank with a valid/ready request port,
// per-byte write enables, a fixed read latency pipeline and a hardware
// init sweep that fills the array with INIT_VALUE after every reset.
module sram_sync_bank #(
    parameter int unsigned           ADDR_WIDTH   = 8,
    parameter int unsigned           DATA_WIDTH   = 16,
    parameter int unsigned           MEM_SIZE     = 256,
    parameter int unsigned           READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    init_done
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IW-1:0]           r_cnt;
    logic                    w_sweep_last;

    logic [DATA_WIDTH-1:0]   r_mem [MEM_SIZE];

    logic [IW-1:0]           w_idx;
    logic                    w_in_range;
    logic                    w_accept;
    logic                    w_wr_accept;
    logic                    w_rd_accept;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    logic [READ_LATENCY-1:0] r_vld;
    logic [READ_LATENCY-1:0] r_err;
    logic [DATA_WIDTH-1:0]   r_dat [READ_LATENCY];

    assign w_sweep_last = (32'(r_cnt) == MEM_SIZE - 1);
    assign w_idx        = req_addr[IW-1:0];
    assign w_in_range   = (32'(req_addr) < MEM_SIZE);
    assign w_accept     = req_valid & req_ready;
    assign w_wr_accept  = w_accept & req_we & w_in_range;
    assign w_rd_accept  = w_accept & ~req_we;
    assign w_rd_word    = w_in_range ? r_mem[w_idx] : '0;

    // State register and sweep counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_INIT && !w_sweep_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Next-state and port-status decode
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        init_done    = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (w_sweep_last) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    // Array write port: init sweep, then byte-masked writes in range only
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_INIT) begin
                r_mem[r_cnt] <= INIT_VALUE;
            end else if (w_wr_accept) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (req_be[b]) begin
                        r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read pipeline; data stages only load when a valid response moves in,
    // so the output word holds between responses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_err <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd_accept;
            r_err[0] <= w_rd_accept & ~w_in_range;
            if (w_rd_accept) begin
                r_dat[0] <= w_rd_word;
            end
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
                if (r_vld[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end
    end

    assign rsp_valid = r_vld[READ_LATENCY-1];
    assign rsp_err   = r_err[READ_LATENCY-1];
    assign rsp_rdata = r_dat[READ_LATENCY-1];

endmodule

// File: tb/tb_sram_sync_bank.sv
// Directed bench for sram_sync_bank. Three instances share clock, reset and
// request inputs: A (defaults), B (READ_LATENCY=3), C (MEM_SIZE=200,
// INIT_VALUE=16'h5A5A). Each test task drives stimulus and checks inline.
module tb_sram_sync_bank;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [1:0]  req_be;
    logic [15:0] req_wdata;

    logic        ready_a, valid_a, err_a, done_a;
    logic [15:0] rdata_a;
    logic        ready_b, valid_b, err_b, done_b;
    logic [15:0] rdata_b;
    logic        ready_c, valid_c, err_c, done_c;
    logic [15:0] rdata_c;

    int n_cmp = 0;
    int n_bad = 0;

    sram_sync_bank #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_SIZE(256), .READ_LATENCY(1), .INIT_VALUE(16'h0000)
    ) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .rsp_valid(valid_a),
        .rsp_rdata(rdata_a), .rsp_err(err_a), .init_done(done_a)
    );

    sram_sync_bank #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_SIZE(256), .READ_LATENCY(3), .INIT_VALUE(16'h0000)
    ) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .rsp_valid(valid_b),
        .rsp_rdata(rdata_b), .rsp_err(err_b), .init_done(done_b)
    );

    sram_sync_bank #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_SIZE(200), .READ_LATENCY(1), .INIT_VALUE(16'h5A5A)
    ) u_dut_c (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_c), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .rsp_valid(valid_c),
        .rsp_rdata(rdata_c), .rsp_err(err_c), .init_done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [7:0] addr, input logic [1:0] be,
                         input logic [15:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wd;
    endtask

    task automatic idle;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 2'b00;
    endtask

    // One request accepted at the next edge; returns #1 after that edge
    task automatic single(input logic we, input logic [7:0] addr, input logic [1:0] be,
                          input logic [15:0] wd);
        drive(we, addr, be, wd);
        tick;
        idle;
    endtask

    // Counts edges after the reset edge until each instance raises req_ready
    task automatic wait_ready(output int na, output int nb, output int nc, output logic seen_rsp);
        na = 1000; nb = 1000; nc = 1000; seen_rsp = 1'b0;
        for (int n = 1; n <= 1000; n++) begin
            tick;
            if (valid_a || valid_b || valid_c) seen_rsp = 1'b1;
            if (na == 1000 && ready_a) na = n;
            if (nb == 1000 && ready_b) nb = n;
            if (nc == 1000 && ready_c) nc = n;
            if (na != 1000 && nb != 1000 && nc != 1000) break;
        end
    endtask

    task automatic test_reset;
        int na, nb, nc;
        logic seen;
        rst = 1'b1;
        idle;
        tick;
        tick;
        n_cmp++; if (ready_a !== 1'b0) begin n_bad++; $display("FAIL rst_ready_a: got %b want 0", ready_a); end
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL rst_done_a: got %b want 0", done_a); end
        n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL rst_valid_a: got %b want 0", valid_a); end
        n_cmp++; if (rdata_a !== 16'h0000) begin n_bad++; $display("FAIL rst_rdata_a: got %h want 0000", rdata_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL rst_err_a: got %b want 0", err_a); end
        n_cmp++; if (valid_b !== 1'b0) begin n_bad++; $display("FAIL rst_valid_b: got %b want 0", valid_b); end
        n_cmp++; if (ready_c !== 1'b0) begin n_bad++; $display("FAIL rst_ready_c: got %b want 0", ready_c); end
        rst = 1'b0;
        wait_ready(na, nb, nc, seen);
        n_cmp++; if (na !== 256) begin n_bad++; $display("FAIL sweep_len_a: got %0d want 256", na); end
        n_cmp++; if (nb !== 256) begin n_bad++; $display("FAIL sweep_len_b: got %0d want 256", nb); end
        n_cmp++; if (nc !== 200) begin n_bad++; $display("FAIL sweep_len_c: got %0d want 200", nc); end
        n_cmp++; if (done_a !== 1'b1) begin n_bad++; $display("FAIL init_done_a: got %b want 1", done_a); end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL sweep_rsp: got %b want 0", seen); end
    endtask

    task automatic test_init_read;
        single(1'b0, 8'd0, 2'b00, 16'h0000);
        n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL init0_valid_a: got %b want 1", valid_a); end
        n_cmp++; if (rdata_a !== 16'h0000) begin n_bad++; $display("FAIL init0_rdata_a: got %h want 0000", rdata_a); end
        n_cmp++; if (rdata_c !== 16'h5A5A) begin n_bad++; $display("FAIL init0_rdata_c: got %h want 5a5a", rdata_c); end
        n_cmp++; if (valid_b !== 1'b0) begin n_bad++; $display("FAIL init0_early_b: got %b want 0", valid_b); end
        tick;
        n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL init0_pulse_a: got %b want 0", valid_a); end
        tick;
        n_cmp++; if (valid_b !== 1'b1) begin n_bad++; $display("FAIL init0_valid_b: got %b want 1", valid_b); end
        n_cmp++; if (rdata_b !== 16'h0000) begin n_bad++; $display("FAIL init0_rdata_b: got %h want 0000", rdata_b); end
        single(1'b0, 8'd128, 2'b00, 16'h0000);
        n_cmp++; if (rdata_c !== 16'h5A5A) begin n_bad++; $display("FAIL init128_rdata_c: got %h want 5a5a", rdata_c); end
        n_cmp++; if (err_c !== 1'b0) begin n_bad++; $display("FAIL init128_err_c: got %b want 0", err_c); end
    endtask

    task automatic test_byte_enable;
        single(1'b1, 8'd5, 2'b11, 16'h1234);
        n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL wr_norsp_a: got %b want 0", valid_a); end
        single(1'b1, 8'd5, 2'b10, 16'hAB55);
        single(1'b1, 8'd5, 2'b00, 16'hFFFF);
        single(1'b0, 8'd5, 2'b00, 16'h0000);
        n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL be_valid_a: got %b want 1", valid_a); end
        n_cmp++; if (rdata_a !== 16'hAB34) begin n_bad++; $display("FAIL be_rdata_a: got %h want ab34", rdata_a); end
        n_cmp++; if (rdata_c !== 16'hAB34) begin n_bad++; $display("FAIL be_rdata_c: got %h want ab34", rdata_c); end
        tick;
        tick;
        n_cmp++; if (valid_b !== 1'b1) begin n_bad++; $display("FAIL be_valid_b: got %b want 1", valid_b); end
        n_cmp++; if (rdata_b !== 16'hAB34) begin n_bad++; $display("FAIL be_rdata_b: got %h want ab34", rdata_b); end
    endtask

    task automatic test_back_to_back;
        logic        ea_v [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] ea_d [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h3333, 16'h3333, 16'h3333};
        logic        eb_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] eb_d [6] = '{16'hAB34, 16'hAB34, 16'h1111, 16'h2222, 16'h3333, 16'h3333};
        single(1'b1, 8'd1, 2'b11, 16'h1111);
        single(1'b1, 8'd2, 2'b11, 16'h2222);
        single(1'b1, 8'd3, 2'b11, 16'h3333);
        for (int k = 0; k < 6; k++) begin
            if (k < 3) drive(1'b0, 8'(k + 1), 2'b00, 16'h0000);
            else idle;
            tick;
            n_cmp++; if (valid_a !== ea_v[k]) begin n_bad++; $display("FAIL b2b_valid_a[%0d]: got %b want %b", k, valid_a, ea_v[k]); end
            n_cmp++; if (rdata_a !== ea_d[k]) begin n_bad++; $display("FAIL b2b_rdata_a[%0d]: got %h want %h", k, rdata_a, ea_d[k]); end
            n_cmp++; if (valid_b !== eb_v[k]) begin n_bad++; $display("FAIL b2b_valid_b[%0d]: got %b want %b", k, valid_b, eb_v[k]); end
            n_cmp++; if (rdata_b !== eb_d[k]) begin n_bad++; $display("FAIL b2b_rdata_b[%0d]: got %h want %h", k, rdata_b, eb_d[k]); end
        end
        idle;
    endtask

    task automatic test_read_first;
        drive(1'b0, 8'd7, 2'b00, 16'h0000);
        tick;
        drive(1'b1, 8'd7, 2'b11, 16'hFFFF);
        n_cmp++; if (rdata_a !== 16'h0000) begin n_bad++; $display("FAIL rf_old_a: got %h want 0000", rdata_a); end
        n_cmp++; if (rdata_c !== 16'h5A5A) begin n_bad++; $display("FAIL rf_old_c: got %h want 5a5a", rdata_c); end
        tick;
        idle;
        n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL rf_wr_norsp_a: got %b want 0", valid_a); end
        tick;
        n_cmp++; if (valid_b !== 1'b1) begin n_bad++; $display("FAIL rf_valid_b: got %b want 1", valid_b); end
        n_cmp++; if (rdata_b !== 16'h0000) begin n_bad++; $display("FAIL rf_inflight_b: got %h want 0000", rdata_b); end
        single(1'b0, 8'd7, 2'b00, 16'h0000);
        n_cmp++; if (rdata_a !== 16'hFFFF) begin n_bad++; $display("FAIL rf_new_a: got %h want ffff", rdata_a); end
        n_cmp++; if (rdata_c !== 16'hFFFF) begin n_bad++; $display("FAIL rf_new_c: got %h want ffff", rdata_c); end
    endtask

    task automatic test_out_of_range;
        single(1'b1, 8'd250, 2'b11, 16'hBEEF);
        single(1'b0, 8'd250, 2'b00, 16'h0000);
        n_cmp++; if (rdata_a !== 16'hBEEF) begin n_bad++; $display("FAIL oor_rdata_a: got %h want beef", rdata_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL oor_err_a: got %b want 0", err_a); end
        n_cmp++; if (valid_c !== 1'b1) begin n_bad++; $display("FAIL oor_valid_c: got %b want 1", valid_c); end
        n_cmp++; if (err_c !== 1'b1) begin n_bad++; $display("FAIL oor_err_c: got %b want 1", err_c); end
        n_cmp++; if (rdata_c !== 16'h0000) begin n_bad++; $display("FAIL oor_rdata_c: got %h want 0000", rdata_c); end
        tick;
        n_cmp++; if (err_c !== 1'b0) begin n_bad++; $display("FAIL oor_err_drop_c: got %b want 0", err_c); end
        single(1'b0, 8'd199, 2'b00, 16'h0000);
        n_cmp++; if (rdata_c !== 16'h5A5A) begin n_bad++; $display("FAIL oor_last_c: got %h want 5a5a", rdata_c); end
        n_cmp++; if (err_c !== 1'b0) begin n_bad++; $display("FAIL oor_last_err_c: got %b want 0", err_c); end
        single(1'b0, 8'd200, 2'b00, 16'h0000);
        n_cmp++; if (err_c !== 1'b1) begin n_bad++; $display("FAIL oor_first_err_c: got %b want 1", err_c); end
        n_cmp++; if (rdata_c !== 16'h0000) begin n_bad++; $display("FAIL oor_first_rdata_c: got %h want 0000", rdata_c); end
        tick;
        tick;
    endtask

    task automatic test_reset_inflight;
        int na, nb, nc;
        logic seen;
        drive(1'b0, 8'd5, 2'b00, 16'h0000);
        tick;
        drive(1'b0, 8'd250, 2'b00, 16'h0000);
        tick;
        idle;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++; if (valid_b !== 1'b0) begin n_bad++; $display("FAIL rif_drop_b: got %b want 0", valid_b); end
        n_cmp++; if (rdata_a !== 16'h0000) begin n_bad++; $display("FAIL rif_rdata_a: got %h want 0000", rdata_a); end
        n_cmp++; if (ready_a !== 1'b0) begin n_bad++; $display("FAIL rif_ready_a: got %b want 0", ready_a); end
        wait_ready(na, nb, nc, seen);
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rif_ghost_rsp: got %b want 0", seen); end
        n_cmp++; if (na !== 256) begin n_bad++; $display("FAIL rif_sweep_a: got %0d want 256", na); end
        n_cmp++; if (nc !== 200) begin n_bad++; $display("FAIL rif_sweep_c: got %0d want 200", nc); end
        single(1'b0, 8'd5, 2'b00, 16'h0000);
        n_cmp++; if (rdata_a !== 16'h0000) begin n_bad++; $display("FAIL rif_init_a: got %h want 0000", rdata_a); end
        n_cmp++; if (rdata_c !== 16'h5A5A) begin n_bad++; $display("FAIL rif_init_c: got %h want 5a5a", rdata_c); end
        tick;
        tick;
        n_cmp++; if (rdata_b !== 16'h0000) begin n_bad++; $display("FAIL rif_init_b: got %h want 0000", rdata_b); end
        single(1'b0, 8'd250, 2'b00, 16'h0000);
        n_cmp++; if (rdata_a !== 16'h0000) begin n_bad++; $display("FAIL rif_init250_a: got %h want 0000", rdata_a); end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        test_reset;
        test_init_read;
        test_byte_enable;
        test_back_to_back;
        test_read_first;
        test_out_of_range;
        test_reset_inflight;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
